// File: rtl/collision_hp_unit.sv
// Heart/bullet collision detector and player hit-point tracker.
// Overlaps are gathered across a video frame and resolved once, on the last pixel of the frame.
module collision_hp_unit #(
  parameter int MAX_HP      = 20,
  parameter int DAMAGE      = 4,
  parameter int IFRAMES     = 30,
  parameter int FIGHT_STATE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       heartSpriteOn,
  input  logic [2:0] bulletSpriteOn,
  output logic [2:0] collision,
  output logic [6:0] hp,
  output logic       invuln,
  output logic       gameOver
);

  localparam logic [1:0] READY = 2'd0;
  localparam logic [1:0] HURT  = 2'd1;
  localparam logic [1:0] DEAD  = 2'd2;

  localparam int              CNT_W    = (IFRAMES < 2) ? 1 : $clog2(IFRAMES + 1);
  localparam logic [6:0]       HP_INIT  = 7'(MAX_HP);
  localparam logic [6:0]       DMG      = 7'(DAMAGE);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IFRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       fsm_q, fsm_d;
  logic [6:0]       hp_q, hp_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inv_q, over_q;

  logic       frame_end;
  logic       fighting;
  logic [2:0] hit_now;
  logic [2:0] hit_all;
  logic [6:0] hp_hit;

  assign frame_end = (x == 10'd639) && (y == 10'd479);
  assign fighting  = (state == 4'(FIGHT_STATE));
  assign hit_now   = (fsm_q == READY && fighting && heartSpriteOn) ? bulletSpriteOn : 3'b000;
  // The frame-end pixel itself still belongs to the frame being resolved.
  assign hit_all   = pend_q | hit_now;
  assign hp_hit    = (hp_q > DMG) ? (hp_q - DMG) : 7'd0;

  always_comb begin
    fsm_d  = fsm_q;
    hp_d   = hp_q;
    cnt_d  = cnt_q;
    coll_d = 3'b000;
    pend_d = hit_all;
    if (frame_end) begin
      // Pending hits never survive a frame end: they are either resolved or discarded.
      pend_d = 3'b000;
      if (state == 4'd0) begin
        hp_d  = HP_INIT;
        cnt_d = '0;
        fsm_d = READY;
      end else begin
        case (fsm_q)
          READY: begin
            if (fighting && hit_all != 3'b000) begin
              coll_d = hit_all;
              hp_d   = hp_hit;
              cnt_d  = CNT_INIT;
              fsm_d  = (hp_hit == 7'd0) ? DEAD : HURT;
            end
          end
          HURT: begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d = '0;
              fsm_d = READY;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= READY;
      hp_q   <= HP_INIT;
      pend_q <= 3'b000;
      cnt_q  <= '0;
      coll_q <= 3'b000;
      inv_q  <= 1'b0;
      over_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      hp_q   <= hp_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      coll_q <= coll_d;
      inv_q  <= (fsm_d == HURT);
      over_q <= (fsm_d == DEAD);
    end
  end

  assign collision = coll_q;
  assign hp        = hp_q;
  assign invuln    = inv_q;
  assign gameOver  = over_q;

endmodule

// File: tb/tb_collision_hp_unit.sv
// Bench for collision_hp_unit: frame-level reference model, per-cycle compare, directed literal checks.
module tb_collision_hp_unit;

  localparam int MAXHP = 20;
  localparam int DMG   = 4;
  localparam int IFR   = 30;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] state = 4'd1;
  logic [9:0] x     = 10'd0;
  logic [9:0] y     = 10'd0;
  logic       heart = 1'b0;
  logic [2:0] bul   = 3'b000;
  logic [2:0] collision;
  logic [6:0] hp;
  logic       invuln;
  logic       gameOver;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  collision_hp_unit #(
    .MAX_HP(MAXHP), .DAMAGE(DMG), .IFRAMES(IFR), .FIGHT_STATE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .x(x), .y(y),
    .heartSpriteOn(heart), .bulletSpriteOn(bul),
    .collision(collision), .hp(hp), .invuln(invuln), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: hp, frames of invulnerability left, dead flag, bullets touched this frame.
  int         m_hp   = MAXHP;
  int         m_left = 0;
  bit         m_dead = 1'b0;
  logic [2:0] m_mask = 3'b000;
  logic [2:0] m_coll = 3'b000;
  logic       fe;
  logic [2:0] touch, acc;
  int         newhp;

  assign fe    = (x == 10'd639) && (y == 10'd479);
  assign touch = (state == 4'd1 && m_left == 0 && !m_dead && heart) ? bul : 3'b000;
  assign acc   = m_mask | touch;
  assign newhp = (m_hp > DMG) ? m_hp - DMG : 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hp <= MAXHP; m_left <= 0; m_dead <= 1'b0; m_mask <= 3'b000; m_coll <= 3'b000;
    end else if (!fe) begin
      m_mask <= acc;
      m_coll <= 3'b000;
    end else begin
      m_mask <= 3'b000;
      m_coll <= 3'b000;
      if (state == 4'd0) begin
        m_hp <= MAXHP; m_left <= 0; m_dead <= 1'b0;
      end else if (m_dead) begin
        m_dead <= 1'b1;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (state == 4'd1 && acc != 3'b000) begin
        m_coll <= acc;
        m_hp   <= newhp;
        if (newhp == 0) m_dead <= 1'b1;
        else m_left <= IFR;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("collision", int'(collision), int'(m_coll));
      chk("hp", int'(hp), m_hp);
      chk("invuln", int'(invuln), int'(m_left > 0));
      chk("gameOver", int'(gameOver), int'(m_dead));
    end
  end

  task automatic cyc(input logic [3:0] st, input logic [9:0] xx, input logic [9:0] yy,
                     input logic h, input logic [2:0] b);
    state = st; x = xx; y = yy; heart = h; bul = b;
    @(posedge clk);
    #1;
  endtask

  // n overlap pixels in state st, then one idle pixel and the frame-end pixel in state st_fe.
  task automatic frame(input logic [3:0] st, input logic [3:0] st_fe, input logic h,
                       input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) cyc(st, 10'(100 + i), 10'd200, h, b);
    cyc(st_fe, 10'd5, 10'd5, 1'b0, 3'b000);
    cyc(st_fe, 10'd639, 10'd479, 1'b0, 3'b000);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) frame(4'd1, 4'd1, 1'b0, 3'b000, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] st;
    logic [9:0] rx, ry;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_hp", int'(hp), 20);
    chk("rst_coll", int'(collision), 0);
    chk("rst_invuln", int'(invuln), 0);
    chk("rst_gameover", int'(gameOver), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Single bullet, five overlap pixels, detection right after reset release.
    frame(4'd1, 4'd1, 1'b1, 3'b001, 5);
    chk("hit1_coll", int'(collision), 1);
    chk("hit1_hp", int'(hp), 16);
    chk("hit1_invuln", int'(invuln), 1);
    cyc(4'd1, 10'd0, 10'd0, 1'b0, 3'b000);
    chk("hit1_pulse_end", int'(collision), 0);

    // Invulnerability window.
    for (int k = 0; k < IFR - 1; k++) frame(4'd1, 4'd1, 1'b1, 3'b001, 2);
    chk("ifr_hp", int'(hp), 16);
    chk("ifr_invuln29", int'(invuln), 1);
    frame(4'd1, 4'd1, 1'b1, 3'b100, 2);
    chk("ifr_invuln30", int'(invuln), 0);
    chk("ifr_coll30", int'(collision), 0);
    chk("ifr_hp30", int'(hp), 16);

    // Two bullets in one frame cost one DAMAGE.
    frame(4'd1, 4'd1, 1'b1, 3'b101, 3);
    chk("dual_coll", int'(collision), 5);
    chk("dual_hp", int'(hp), 12);

    // Leaving the fight state before frame end discards the pending hit.
    idle_frames(IFR);
    chk("leave_ready", int'(invuln), 0);
    frame(4'd1, 4'd2, 1'b1, 3'b010, 3);
    chk("leave_coll", int'(collision), 0);
    chk("leave_hp", int'(hp), 12);
    idle_frames(1);
    chk("leave_coll2", int'(collision), 0);
    chk("leave_hp2", int'(hp), 12);

    // Hit down to zero.
    for (int k = 0; k < 3; k++) begin
      frame(4'd1, 4'd1, 1'b1, 3'b001, 1);
      if (k < 2) idle_frames(IFR);
    end
    chk("dead_hp", int'(hp), 0);
    chk("dead_flag", int'(gameOver), 1);
    chk("dead_invuln", int'(invuln), 0);
    for (int k = 0; k < 3; k++) frame(4'd1, 4'd1, 1'b1, 3'b111, 2);
    chk("dead_hp2", int'(hp), 0);
    chk("dead_flag2", int'(gameOver), 1);
    frame(4'd1, 4'd0, 1'b0, 3'b000, 1);
    chk("menu_hp", int'(hp), 20);
    chk("menu_flag", int'(gameOver), 0);

    // Overlap only on the frame-end pixel.
    cyc(4'd1, 10'd639, 10'd479, 1'b1, 3'b010);
    chk("fe_overlap_coll", int'(collision), 2);
    chk("fe_overlap_hp", int'(hp), 16);
    chk("fe_overlap_invuln", int'(invuln), 1);

    // Asynchronous reset while hurt.
    idle_frames(2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_hp", int'(hp), 20);
    chk("arst_invuln", int'(invuln), 0);
    chk("arst_gameover", int'(gameOver), 0);
    chk("arst_coll", int'(collision), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Randomized frames against the model.
    for (int f = 0; f < 400; f++) begin
      int r;
      int n;
      r = int'($urandom_range(0, 19));
      st = (r == 0) ? 4'd0 : (r < 3) ? 4'd2 : 4'd1;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        rx = 10'($urandom_range(0, 639));
        ry = 10'($urandom_range(0, 479));
        if (rx == 10'd639 && ry == 10'd479) ry = 10'd478;
        cyc(($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 3)) : st, rx, ry,
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
      end
      cyc(st, 10'd639, 10'd479, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) == 0) begin
        #3 rst_n = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_hp_unit.md
COLLISION_HP_UNIT -- requirements
Module: collision_hp_unit

Interface
REQ-001 SHALL have parameter MAX_HP, default 20, player hit points at start of a fight.
REQ-002 SHALL have parameter DAMAGE, default 4, HP removed per registered hit.
REQ-003 SHALL have parameter IFRAMES, default 30, invulnerability length in video frames after a hit.
REQ-004 SHALL have parameter FIGHT_STATE, default 1, value of state meaning "bullets active".
REQ-005 clk  input  1  pixel clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 state  input  4  game state; FIGHT_STATE enables detection; 0 is menu.
REQ-008 x, y  input  10 each  current scan position, 0..639 / 0..479.
REQ-009 heartSpriteOn  input  1  player heart covers current pixel.
REQ-010 bulletSpriteOn  input  3  bit i: bullet i covers current pixel.
REQ-011 collision  output  3  bit i: one-cycle pulse telling bullet i it hit; bullet latches its own dead state.
REQ-012 hp  output  7  current hit points, 0..MAX_HP.
REQ-013 invuln  output  1  high during invulnerability (drives heart blink).
REQ-014 gameOver  output  1  high while in DEAD state.

Function
REQ-015 SHALL implement FSM with states READY, HURT, DEAD; all outputs registered.
REQ-016 Frame end SHALL be the cycle with x==639 and y==479; all HP/FSM updates occur only on that cycle.
REQ-017 In READY with state==FIGHT_STATE, each cycle where heartSpriteOn && bulletSpriteOn[i] SHALL set sticky pending bit i.
REQ-018 Pending bits SHALL NOT be set in HURT or DEAD, or when state!=FIGHT_STATE.
REQ-019 At frame end with pending!=0 in READY: collision <= pending for exactly one cycle; pending cleared; hp <= hp-DAMAGE saturating at 0; frame counter <= IFRAMES.
REQ-020 Multiple bullets hitting in one frame SHALL cost DAMAGE once; all hit bullets receive their collision bit.
REQ-021 After REQ-019, if new hp==0 FSM SHALL go to DEAD, else to HURT.
REQ-022 In HURT, frame counter SHALL decrement by 1 each frame end; when it is 1 at frame end it SHALL reach 0 and FSM return to READY on that same edge.
REQ-023 invuln SHALL be 1 exactly while FSM is HURT.
REQ-024 gameOver SHALL be 1 exactly while FSM is DEAD; DEAD exits only via REQ-025 or reset.
REQ-025 When state==0 on a frame end, hp <= MAX_HP, pending cleared, counter 0, FSM -> READY, from any FSM state.
REQ-026 Pending collected in a frame where state leaves FIGHT_STATE before frame end SHALL be discarded at that frame end without damage or collision pulse.
REQ-027 collision SHALL be 0 on every cycle other than the REQ-019 pulse.
REQ-028 Frame-end check and pixel overlap on the same cycle: overlap at (639,479) SHALL count toward the current frame.

Reset
REQ-029 While rst_n low: hp=MAX_HP, FSM=READY, pending=0, counter=0, collision=0, invuln=0, gameOver=0.
REQ-030 Reset deassertion mid-frame SHALL start detection on the next clk edge without waiting for frame end.

Verification
REQ-031 state=1, overlap bullet0 for 5 pixels in one frame -> at frame end collision=3'b001 one cycle, hp 20->16, invuln=1.
REQ-032 Bullets 0 and 2 overlap same frame -> collision=3'b101, hp drops by 4 only.
REQ-033 Hit, then overlaps in following 30 frames -> no pulse, hp unchanged; invuln falls at 30th frame end; next overlap hits again.
REQ-034 Five hits spaced past iframes -> hp 20->0, gameOver=1; further overlaps ignored; state=0 at frame end -> hp=20, gameOver=0.
REQ-035 Overlap then state->2 before frame end -> no collision, hp unchanged.
REQ-036 rst_n pulsed low mid-HURT -> all outputs at reset values immediately, asynchronous to clk.
